// File: rtl/wb_pkg.sv
// Shared types and default widths for the shared Wishbone bus.
// Holds the bus FSM state encoding and a SEL width helper.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } bus_state_e;

    localparam int unsigned DEF_MASTER_COUNT   = 2;
    localparam int unsigned DEF_ADDR_WIDTH     = 24;
    localparam int unsigned DEF_DATA_WIDTH     = 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    function automatic int unsigned sel_width(input int unsigned dw);
        return (dw / 8 < 1) ? 1 : dw / 8;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first set request after the last winner.
// Search wraps modulo N; valid_o low when nothing is requested.
module rr_select #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] next_o,
    output logic          valid_o
);

    // Scan last+1 .. last+N and keep the first hit.
    always_comb begin
        next_o  = '0;
        valid_o = 1'b0;
        for (int k = 1; k <= int'(N); k++) begin
            if (!valid_o && req_i[(int'(last_i) + k) % int'(N)]) begin
                next_o  = IW'((int'(last_i) + k) % int'(N));
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_shared_bus.sv
// Multi-master to single-slave Wishbone bus with round-robin grant.
// Define WB_SHARED_BUS_TIMEOUT_EN to build in the stalled-slave watchdog.
module wb_shared_bus
    import wb_pkg::*;
#(
    parameter int unsigned MASTER_COUNT   = DEF_MASTER_COUNT,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int unsigned SEL_WIDTH     = sel_width(DATA_WIDTH),
    localparam int unsigned GW            = $clog2(MASTER_COUNT)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [MASTER_COUNT-1:0]            m_cyc_i,
    input  logic [MASTER_COUNT-1:0]            m_stb_i,
    input  logic [MASTER_COUNT-1:0]            m_we_i,
    input  logic [MASTER_COUNT*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [MASTER_COUNT*DATA_WIDTH-1:0] m_dat_i,
    input  logic [MASTER_COUNT*SEL_WIDTH-1:0]  m_sel_i,
    output logic [MASTER_COUNT-1:0]            m_ack_o,
    output logic [MASTER_COUNT-1:0]            m_err_o,
    output logic [DATA_WIDTH-1:0]              m_dat_o,
    output logic                               s_cyc_o,
    output logic                               s_stb_o,
    output logic                               s_we_o,
    output logic [ADDR_WIDTH-1:0]              s_adr_o,
    output logic [DATA_WIDTH-1:0]              s_dat_o,
    output logic [SEL_WIDTH-1:0]               s_sel_o,
    input  logic                               s_ack_i,
    input  logic [DATA_WIDTH-1:0]              s_dat_i,
    output logic [GW-1:0]                      gnt_o
);

    if (MASTER_COUNT < 2 || MASTER_COUNT > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("wb_shared_bus: unsupported parameter set");
    end

    bus_state_e    state_q, state_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [GW-1:0] last_q, last_d;
    logic [GW-1:0] rr_next;
    logic          rr_valid;
    logic          busy;
    logic          own_cyc;
    logic          timeout;

    assign busy    = (state_q == BUSY);
    assign own_cyc = m_cyc_i[gnt_q];

    rr_select #(
        .N  (MASTER_COUNT),
        .IW (GW)
    ) u_rr (
        .req_i   (m_cyc_i),
        .last_i  (last_q),
        .next_o  (rr_next),
        .valid_o (rr_valid)
    );

`ifdef WB_SHARED_BUS_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_q, wd_d;

    assign timeout = busy && (wd_q >= CW'(TIMEOUT_CYCLES));

    // Count stalled strobe cycles of the current owner; clear otherwise.
    always_comb begin
        wd_d = '0;
        if (busy && state_d == BUSY && s_stb_o && !s_ack_i) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Bus FSM state, current grant and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= GW'(MASTER_COUNT - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state: grant from IDLE, leave BUSY on drop or timeout.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (rr_valid) begin
                    state_d = BUSY;
                    gnt_d   = rr_next;
                    last_d  = rr_next;
                end
            end
            BUSY: begin
                if (!own_cyc || timeout) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Slave side follows the owner; ack/err routed only to the owner.
    always_comb begin
        s_cyc_o = busy;
        s_stb_o = busy && m_stb_i[gnt_q];
        s_we_o  = m_we_i[gnt_q];
        s_adr_o = m_adr_i[int'(gnt_q)*ADDR_WIDTH +: ADDR_WIDTH];
        s_dat_o = m_dat_i[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
        s_sel_o = m_sel_i[int'(gnt_q)*SEL_WIDTH +: SEL_WIDTH];
        m_dat_o = s_dat_i;
        gnt_o   = gnt_q;
        m_ack_o = '0;
        m_err_o = '0;
        if (busy && rst_ni) begin
            m_ack_o[gnt_q] = s_ack_i;
            m_err_o[gnt_q] = timeout;
        end
    end

endmodule

// File: tb/tb_wb_shared_bus.sv
// Scoreboard bench for wb_shared_bus against an ownership-level model.
// Driver pushes expected outputs; a negedge monitor pops and compares.
module tb_wb_shared_bus;

    localparam int MC = 2;
    localparam int AW = 24;
    localparam int DW = 8;
    localparam int SW = 1;
    localparam int GW = 1;
`ifdef WB_SHARED_BUS_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [MC-1:0]     m_cyc_i, m_stb_i, m_we_i;
    logic [MC*AW-1:0]  m_adr_i;
    logic [MC*DW-1:0]  m_dat_i;
    logic [MC*SW-1:0]  m_sel_i;
    logic [MC-1:0]     m_ack_o, m_err_o;
    logic [DW-1:0]     m_dat_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_ack_i;
    logic [DW-1:0]     s_dat_i;
    logic [GW-1:0]     gnt_o;

    wb_shared_bus #(
        .MASTER_COUNT   (MC),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_dat_o (m_dat_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_ack_i (s_ack_i),
        .s_dat_i (s_dat_i),
        .gnt_o   (gnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          s_cyc, s_stb, s_we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        logic [GW-1:0] gnt;
        logic [MC-1:0] ack, err;
        logic [DW-1:0] mdat;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model: who owns the bus, whether a gap cycle follows, turn pointer.
    int   owner = -1;
    bit   gap = 0;
    int   last = MC - 1;
    int   gval = 0;
    int   wd = 0;
    int   hist[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        exp_t e;
        bit   tmo;
        tmo = (owner >= 0) && (wd >= TO);
`ifndef WB_SHARED_BUS_TIMEOUT_EN
        tmo = 0;
`endif
        e = '{default: '0};
        e.s_cyc = owner >= 0;
        e.gnt   = GW'(gval);
        e.mdat  = s_dat_i;
        if (owner >= 0) begin
            e.s_stb = m_stb_i[owner];
            e.s_we  = m_we_i[owner];
            e.adr   = m_adr_i[owner*AW +: AW];
            e.dat   = m_dat_i[owner*DW +: DW];
            e.sel   = m_sel_i[owner*SW +: SW];
            if (rst_ni) begin
                e.ack[owner] = s_ack_i;
                e.err[owner] = tmo;
            end
        end
        q.push_back(e);
        if (!rst_ni) begin
            owner = -1; gap = 0; last = MC - 1; gval = 0; wd = 0;
        end else if (owner >= 0) begin
            if (!m_cyc_i[owner] || tmo) begin
                owner = -1; gap = 1; wd = 0;
            end else if (m_stb_i[owner] && !s_ack_i) begin
                wd++;
            end else begin
                wd = 0;
            end
        end else if (gap) begin
            gap = 0;
        end else begin
            for (int k = 1; k <= MC; k++) begin
                if (m_cyc_i[(last + k) % MC]) begin
                    owner = (last + k) % MC;
                    last  = owner;
                    gval  = owner;
                    hist.push_back(owner);
                    break;
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("s_cyc", 64'(s_cyc_o), 64'(e.s_cyc));
            chk("gnt", 64'(gnt_o), 64'(e.gnt));
            chk("s_stb", 64'(s_stb_o), 64'(e.s_stb));
            chk("m_ack", 64'(m_ack_o), 64'(e.ack));
            chk("m_err", 64'(m_err_o), 64'(e.err));
            chk("m_dat", 64'(m_dat_o), 64'(e.mdat));
            if (e.s_cyc) begin
                chk("s_adr", 64'(s_adr_o), 64'(e.adr));
                chk("s_dat", 64'(s_dat_o), 64'(e.dat));
                chk("s_sel", 64'(s_sel_o), 64'(e.sel));
                chk("s_we", 64'(s_we_o), 64'(e.s_we));
            end
        end
    end

    initial begin
        int acks;
        int n0;
        rst_ni = 0;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        s_ack_i = 0; s_dat_i = '0;
        @(posedge clk_i);
        #1;
        step();
        step();
        // Both request: master 0 first, then ack routed to it.
        rst_ni = 1;
        m_cyc_i = 2'b11; m_stb_i = 2'b11; s_dat_i = 8'h3C;
        step();
        s_ack_i = 1;
        step();
        s_ack_i = 0;
        // Master 0 leaves; master 1 gets the bus after the gap.
        m_cyc_i = 2'b10;
        step();
        step();
        step();
        // Master 1 write is passed through untouched.
        m_we_i = 2'b10;
        m_adr_i = {24'h00_1234, 24'hFF_FFFF};
        m_dat_i = {8'hA5, 8'h5A};
        m_sel_i = 2'b10;
        s_ack_i = 1;
        step();
        s_ack_i = 0;
        m_cyc_i = 2'b00;
        step();
        step();
        // Continuous requests, each owner drops after three acks.
        n0 = hist.size();
        acks = 0;
        for (int n = 0; n < 40; n++) begin
            m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 0;
            if (owner >= 0 && acks == 3) begin
                m_cyc_i[owner] = 1'b0;
                acks = 0;
            end else if (owner >= 0) begin
                s_ack_i = 1;
                acks++;
            end
            step();
        end
        for (int j = n0 + 1; j < hist.size(); j++) begin
            chk("alternate", 64'(hist[j]), 64'(hist[j-1] ^ 1));
        end
        // Reset in the middle of a transfer.
        m_cyc_i = 2'b01; s_ack_i = 0;
        step();
        step();
        rst_ni = 0; s_ack_i = 1;
        step();
        rst_ni = 1; s_ack_i = 0; m_cyc_i = 2'b00;
        step();
        step();
`ifdef WB_SHARED_BUS_TIMEOUT_EN
        // Slave never answers: owner gets a single error pulse.
        m_cyc_i = 2'b01; m_stb_i = 2'b01; s_ack_i = 0;
        for (int n = 0; n < 12; n++) step();
        m_cyc_i = 2'b00;
        step();
        step();
`endif
        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            for (int m = 0; m < MC; m++) begin
                if ($urandom_range(7) == 0) m_cyc_i[m] = ~m_cyc_i[m];
            end
            m_stb_i = MC'($urandom);
            m_we_i  = MC'($urandom);
            m_adr_i = (MC*AW)'({$urandom, $urandom});
            m_dat_i = (MC*DW)'($urandom);
            m_sel_i = (MC*SW)'($urandom);
            s_dat_i = DW'($urandom);
            s_ack_i = ($urandom_range(2) == 0);
            rst_ni  = ($urandom_range(149) != 0);
            step();
        end
        rst_ni = 1;
        for (int n = 0; n < 10 && q.size() > 0; n++) @(negedge clk_i);
        #1;
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain got %0d left want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_shared_bus.md
WB_SHARED_BUS -- requirements
Module: wb_shared_bus

Interface
REQ-001 SHALL have parameter MASTER_COUNT, default 2, number of Wishbone masters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 24, address bits.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, data bits; SEL_WIDTH = DATA_WIDTH/8, minimum 1.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit in cycles.
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk_i  input  1  rising-edge clock; rst_ni  input  1  synchronous active-low reset.
REQ-006 SHALL have m_cyc_i, m_stb_i, m_we_i  input  MASTER_COUNT  per-master cycle, strobe and write-enable.
REQ-007 SHALL have m_adr_i  input  MASTER_COUNT*ADDR_WIDTH  packed per-master address; master i occupies slice i.
REQ-008 SHALL have m_dat_i  input  MASTER_COUNT*DATA_WIDTH  and m_sel_i  input  MASTER_COUNT*SEL_WIDTH, both packed per master.
REQ-009 SHALL have m_ack_o, m_err_o  output  MASTER_COUNT  and m_dat_o  output  DATA_WIDTH  shared read data.
REQ-010 SHALL have s_cyc_o, s_stb_o, s_we_o  output  1;  s_adr_o  output  ADDR_WIDTH;  s_dat_o  output  DATA_WIDTH;  s_sel_o  output  SEL_WIDTH.
REQ-011 SHALL have s_ack_i  input  1  and s_dat_i  input  DATA_WIDTH  from the slave.
REQ-012 SHALL have gnt_o  output  $clog2(MASTER_COUNT)  index of the owning master.

Function
REQ-013 SHALL implement FSM IDLE -> BUSY -> RELEASE -> IDLE.
REQ-014 In IDLE with any m_cyc_i set, SHALL register grant at the next edge and enter BUSY; s_cyc_o SHALL rise in that cycle (1-cycle grant latency).
REQ-015 Grant SHALL be round-robin: search begins at last_gnt+1 modulo MASTER_COUNT; first set m_cyc_i wins.
REQ-016 In BUSY, s_adr_o, s_dat_o, s_sel_o, s_we_o SHALL combinationally follow the granted master; s_stb_o = m_stb_i[gnt_o] gated by BUSY.
REQ-017 m_ack_o[gnt_o] SHALL equal s_ack_i in BUSY, zero for all other masters and states; m_dat_o = s_dat_i unconditionally.
REQ-018 When m_cyc_i[gnt_o] is low in BUSY, SHALL enter RELEASE at the next edge; s_cyc_o low in RELEASE; RELEASE always returns to IDLE after one cycle.
REQ-019 s_ack_i in IDLE or RELEASE SHALL be ignored.
REQ-020 A master dropping m_cyc_i while not granted SHALL have no effect; requests are level-sensitive, never latched.
REQ-021 Non-owner masters SHALL see m_ack_o = m_err_o = 0 regardless of slave activity.

Reset
REQ-022 With rst_ni low at a clock edge: state IDLE, s_cyc_o = 0, gnt_o = 0, last_gnt = MASTER_COUNT-1 (master 0 wins first), watchdog = 0, all m_ack_o/m_err_o = 0.
REQ-023 Reset asserted mid-BUSY SHALL abort the transfer without ack or err.

Configuration
REQ-024 Macro WB_SHARED_BUS_TIMEOUT_EN SHALL compile in a watchdog.
REQ-025 With it defined: counter increments each BUSY cycle with s_stb_o high and s_ack_i low, clears on ack or outside BUSY; reaching TIMEOUT_CYCLES SHALL pulse m_err_o[gnt_o] for one cycle and force RELEASE next edge.
REQ-026 Without it: m_err_o is constant 0, no counter exists, BUSY persists until the owner drops m_cyc_i.

Structure
REQ-027 Shared package wb_pkg SHALL hold the FSM state enum (IDLE, BUSY, RELEASE) and the default width constants.
REQ-028 Round-robin selection SHALL live in sub-module rr_select (request vector + last index -> next index, valid).

Verification
REQ-029 Reset, then m_cyc_i=2'b11 -> gnt_o=0, s_cyc_o high one cycle later; m_ack_o=2'b01 on s_ack_i.
REQ-030 Master 0 drops cyc, master 1 still requesting -> RELEASE, IDLE, then gnt_o=1; no cycle has s_cyc_o high for both owners.
REQ-031 Both masters continuously request, each drops cyc after 3 acks -> grants alternate 0,1,0,1.
REQ-032 Master 1 writes adr=24'h00_1234, dat=8'hA5, sel=1 -> slave sees identical values, we=1; master 0 sees no ack.
REQ-033 With WB_SHARED_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks -> m_err_o[gnt] pulses once after 4 strobe cycles, s_cyc_o falls next cycle.
REQ-034 rst_ni low mid-BUSY -> next cycle s_cyc_o=0, gnt_o=0, no m_ack_o or m_err_o pulse.
